// File: rtl/imm_pkg.sv
// Shared immediate-mode encodings for the immediate extension pipeline.
package imm_pkg;

  localparam int IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_DP8   = 3'b000,
    IMM_LS12  = 3'b001,
    IMM_BR24  = 3'b010,
    IMM_ROT   = 3'b011,
    IMM_LSU12 = 3'b100
  } imm_src_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: zero/sign extension, rotated 8-bit
// immediate with shifter carry, and signed 12-bit offset.
module imm_decode
  import imm_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [23:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  input  logic                 carry_in,
  output logic [WIDTH-1:0]     value,
  output logic                 carry_out,
  output logic                 illegal
);

  logic [31:0]      rot_src;
  logic [4:0]       rot_amt;
  logic [31:0]      rot_val;
  logic [WIDTH-1:0] off12;

  // Rotate right by an even amount; a shift of 32 on the left leg yields 0,
  // so a zero rotation returns the source unchanged.
  always_comb begin
    rot_src = {24'd0, instr[7:0]};
    rot_amt = {instr[11:8], 1'b0};
    rot_val = (rot_src >> rot_amt) | (rot_src << (6'd32 - {1'b0, rot_amt}));
    off12   = WIDTH'(instr[11:0]);
  end

  // Mode select; undefined encodings produce zero and flag illegal.
  always_comb begin
    value     = '0;
    carry_out = carry_in;
    illegal   = 1'b0;
    case (imm_src)
      IMM_DP8:   value = WIDTH'(instr[7:0]);
      IMM_LS12:  value = off12;
      IMM_BR24:  value = WIDTH'($signed(instr)) << BR_SHIFT;
      IMM_ROT: begin
        value = WIDTH'(rot_val);
        if (instr[11:8] != 4'd0) carry_out = rot_val[31];
      end
      IMM_LSU12: value = instr[23] ? off12 : -off12;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready pipeline around imm_decode. S1 captures the raw
// instruction fields, S2 holds the decoded result until consumed.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          Instr,
  input  logic [IMM_SRC_W-1:0] ImmSrc,
  input  logic                 carry_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     ExtImm,
  output logic                 carry_out,
  output logic                 illegal
);

  // live_q gates in_ready so nothing is accepted before the first edge
  // after reset release.
  logic                 live_q;
  logic                 s1_valid_q, s1_valid_d;
  logic [23:0]          s1_instr_q, s1_instr_d;
  logic [IMM_SRC_W-1:0] s1_src_q,   s1_src_d;
  logic                 s1_cin_q,   s1_cin_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_imm_q,   s2_imm_d;
  logic                 s2_cout_q,  s2_cout_d;
  logic                 s2_ill_q,   s2_ill_d;

  logic                 s1_adv;
  logic                 accept;
  logic                 s2_load;
  logic                 consume;
  logic [WIDTH-1:0]     dec_value;
  logic                 dec_cout;
  logic                 dec_ill;

  imm_decode #(
    .WIDTH   (WIDTH),
    .BR_SHIFT(BR_SHIFT)
  ) u_decode (
    .instr    (s1_instr_q),
    .imm_src  (s1_src_q),
    .carry_in (s1_cin_q),
    .value    (dec_value),
    .carry_out(dec_cout),
    .illegal  (dec_ill)
  );

  // Handshake: in_ready depends only on state, flush and out_ready.
  always_comb begin
    consume  = s2_valid_q && out_ready;
    s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = live_q && !flush && (!s1_valid_q || s1_adv);
    accept   = in_valid && in_ready;
    s2_load  = s1_adv && !flush;
  end

  // Next-state for both stages; flush wins over every load.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_src_d   = s1_src_q;
    s1_cin_d   = s1_cin_q;
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_cout_d  = s2_cout_q;
    s2_ill_d   = s2_ill_q;

    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_instr_d = Instr;
      s1_src_d   = ImmSrc;
      s1_cin_d   = carry_in;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_imm_d   = dec_value;
      s2_cout_d  = dec_cout;
      s2_ill_d   = dec_ill;
    end else if (consume) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_src_q   <= '0;
      s1_cin_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_cout_q  <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_src_q   <= s1_src_d;
      s1_cin_q   <= s1_cin_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_cout_q  <= s2_cout_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  // Outputs come straight from S2 so they hold while stalled.
  always_comb begin
    out_valid = s2_valid_q;
    ExtImm    = s2_imm_q;
    carry_out = s2_cout_q;
    illegal   = s2_ill_q;
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a 32-bit and a 64-bit instance share
// stimulus; a vector table covers every mode, then hand sequences cover
// stall, flush and mid-operation reset.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] Instr;
  logic [2:0]  ImmSrc;
  logic        carry_in;
  logic        flush;
  logic        out_ready;

  logic        rdy32, ov32, co32, il32;
  logic [31:0] ext32;
  logic        rdy64, ov64, co64, il64;
  logic [63:0] ext64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.WIDTH(32), .BR_SHIFT(2)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .Instr(Instr), .ImmSrc(ImmSrc), .carry_in(carry_in), .flush(flush),
    .out_valid(ov32), .out_ready(out_ready), .ExtImm(ext32),
    .carry_out(co32), .illegal(il32)
  );

  imm_extend_pipe #(.WIDTH(64), .BR_SHIFT(2)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .Instr(Instr), .ImmSrc(ImmSrc), .carry_in(carry_in), .flush(flush),
    .out_valid(ov64), .out_ready(out_ready), .ExtImm(ext64),
    .carry_out(co64), .illegal(il64)
  );

  typedef struct {
    logic [2:0]  src;
    logic [23:0] instr;
    logic        cin;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        cout;
    logic        ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [23:0] ins, input logic cin);
    in_valid = 1'b1;
    ImmSrc   = src;
    Instr    = ins;
    carry_in = cin;
  endtask

  // Send one vector with out_ready=1 and check exact 2-cycle latency.
  task automatic send_one(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.src, v.instr, v.cin);
    chk({tag, " in_ready"}, 64'(rdy32 & rdy64), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, " early_valid"}, 64'(ov32 | ov64), 64'd0);
    tick();
    chk({tag, " out_valid"}, 64'(ov32 & ov64), 64'd1);
    chk({tag, " ext32"}, 64'(ext32), 64'(v.e32));
    chk({tag, " ext64"}, ext64, v.e64);
    chk({tag, " cout32"}, 64'(co32), 64'(v.cout));
    chk({tag, " cout64"}, 64'(co64), 64'(v.cout));
    chk({tag, " ill32"}, 64'(il32), 64'(v.ill));
    chk({tag, " ill64"}, 64'(il64), 64'(v.ill));
  endtask

  initial begin
    vecs[0]  = '{3'd0, 24'h0000A5, 1'b0, 32'h000000A5, 64'h00000000000000A5, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 24'hFFFF3C, 1'b1, 32'h0000003C, 64'h000000000000003C, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 24'h123ABC, 1'b0, 32'h00000ABC, 64'h0000000000000ABC, 1'b0, 1'b0};
    vecs[3]  = '{3'd2, 24'hFFFFFE, 1'b0, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 24'h7FFFFF, 1'b1, 32'h01FFFFFC, 64'h0000000001FFFFFC, 1'b1, 1'b0};
    vecs[5]  = '{3'd2, 24'h800000, 1'b0, 32'hFE000000, 64'hFFFFFFFFFE000000, 1'b0, 1'b0};
    vecs[6]  = '{3'd3, 24'h0004FF, 1'b0, 32'hFF000000, 64'h00000000FF000000, 1'b1, 1'b0};
    vecs[7]  = '{3'd3, 24'h0000FF, 1'b1, 32'h000000FF, 64'h00000000000000FF, 1'b1, 1'b0};
    vecs[8]  = '{3'd3, 24'h000080, 1'b0, 32'h00000080, 64'h0000000000000080, 1'b0, 1'b0};
    vecs[9]  = '{3'd3, 24'h000102, 1'b0, 32'h80000000, 64'h0000000080000000, 1'b1, 1'b0};
    vecs[10] = '{3'd3, 24'h000104, 1'b1, 32'h00000001, 64'h0000000000000001, 1'b0, 1'b0};
    vecs[11] = '{3'd4, 24'h000004, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    vecs[12] = '{3'd4, 24'h800004, 1'b1, 32'h00000004, 64'h0000000000000004, 1'b1, 1'b0};
    vecs[13] = '{3'd4, 24'h000FFF, 1'b0, 32'hFFFFF001, 64'hFFFFFFFFFFFFF001, 1'b0, 1'b0};
    vecs[14] = '{3'd7, 24'h1234AB, 1'b1, 32'h00000000, 64'h0000000000000000, 1'b1, 1'b1};
    vecs[15] = '{3'd5, 24'hFFFFFF, 1'b0, 32'h00000000, 64'h0000000000000000, 1'b0, 1'b1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    Instr     = '0;
    ImmSrc    = '0;
    carry_in  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick();
    in_valid = 1'b1;
    #1;
    chk("rst out_valid", 64'(ov32 | ov64), 64'd0);
    chk("rst in_ready", 64'(rdy32 | rdy64), 64'd0);
    chk("rst ext", 64'(ext32) | ext64, 64'd0);
    chk("rst cout", 64'(co32 | co64), 64'd0);
    chk("rst ill", 64'(il32 | il64), 64'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst pre_edge in_ready", 64'(rdy32 | rdy64), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst edge in_ready", 64'(rdy32 & rdy64), 64'd1);

    // Table
    for (int i = 0; i < 16; i++) send_one(vecs[i], i);
    tick();
    chk("table drained", 64'(ov32 | ov64), 64'd0);

    // Stall: A, B accepted; C blocked while out_ready=0
    out_ready = 1'b0;
    drive(3'd0, 24'h000011, 1'b0);
    chk("stall A in_ready", 64'(rdy32), 64'd1);
    tick();
    drive(3'd1, 24'h000222, 1'b0);
    chk("stall B in_ready", 64'(rdy32), 64'd1);
    tick();
    drive(3'd4, 24'h800333, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("stall full in_ready", 64'(rdy32), 64'd0);
      chk("stall out_valid", 64'(ov32), 64'd1);
      chk("stall hold ext", 64'(ext32), 64'h11);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 64'(rdy32), 64'd1);
    chk("release A", 64'(ext32), 64'h11);
    tick();
    in_valid = 1'b0;
    chk("order B valid", 64'(ov32), 64'd1);
    chk("order B", 64'(ext32), 64'h222);
    tick();
    chk("order C valid", 64'(ov32), 64'd1);
    chk("order C", 64'(ext32), 64'h333);
    tick();
    chk("order drained", 64'(ov32), 64'd0);

    // Flush with both stages full and a pending input
    out_ready = 1'b0;
    drive(3'd0, 24'h000044, 1'b0);
    tick();
    drive(3'd0, 24'h000055, 1'b0);
    tick();
    drive(3'd0, 24'h000066, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(rdy32 | rdy64), 64'd0);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("flush next out_valid", 64'(ov32 | ov64), 64'd0);
    tick();
    chk("flush no accept", 64'(ov32 | ov64), 64'd0);
    tick();
    chk("flush still empty", 64'(ov32 | ov64), 64'd0);

    // Reset pulse with S1 full
    drive(3'd1, 24'h000777, 1'b0);
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst out_valid", 64'(ov32 | ov64), 64'd0);
    chk("midrst in_ready", 64'(rdy32 | rdy64), 64'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst no output", 64'(ov32 | ov64), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
